// File: rtl/maquina_pkg.sv
// Shared state encoding for the multi-FIFO flow-control machine.
package maquina_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] RESET = 3'd0;
  localparam logic [STATE_W-1:0] INIT  = 3'd1;
  localparam logic [STATE_W-1:0] IDLE  = 3'd2;
  localparam logic [STATE_W-1:0] ACTIVE = 3'd3;
  localparam logic [STATE_W-1:0] ERROR = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = RESET,
    S_INIT   = INIT,
    S_IDLE   = IDLE,
    S_ACTIVE = ACTIVE,
    S_ERROR  = ERROR
  } st_e;

endpackage

// File: rtl/fifo_err_check.sv
// Per-channel FIFO misuse decode: full+empty, push on full, pop on empty.
module fifo_err_check (
  input  logic fifo_empty_i,
  input  logic fifo_full_i,
  input  logic fifo_read_i,
  input  logic fifo_write_i,
  output logic err_o
);

  logic both_flags;
  logic bad_push;
  logic bad_pop;

  assign both_flags = fifo_full_i & fifo_empty_i;
  // A push on full is fine when a pop frees the slot in the same cycle.
  assign bad_push   = fifo_write_i & fifo_full_i & ~fifo_read_i;
  assign bad_pop    = fifo_read_i & fifo_empty_i;
  assign err_o      = both_flags | bad_push | bad_pop;

endmodule

// File: rtl/maquina_estados_multi.sv
// Multi-FIFO supervisor FSM with latched thresholds and sticky error mask.
// Define ERROR_RECOVERY_EN to allow leaving ERROR through init.
module maquina_estados_multi
  import maquina_pkg::*;
#(
  parameter int NUM_FIFOS = 4,
  parameter int UMBRAL_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [UMBRAL_W-1:0]  umbral_mf_in,
  input  logic [UMBRAL_W-1:0]  umbral_vc_in,
  input  logic [UMBRAL_W-1:0]  umbral_d_in,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [NUM_FIFOS-1:0] fifo_full,
  input  logic [NUM_FIFOS-1:0] fifo_read,
  input  logic [NUM_FIFOS-1:0] fifo_write,
  output logic                 init_out,
  output logic                 idle_out,
  output logic                 active_out,
  output logic                 error_out,
  output logic [STATE_W-1:0]   state_out,
  output logic [UMBRAL_W-1:0]  umbral_mf_out,
  output logic [UMBRAL_W-1:0]  umbral_vc_out,
  output logic [UMBRAL_W-1:0]  umbral_d_out,
  output logic [NUM_FIFOS-1:0] error_chan
);

  st_e                  state_q, state_d;
  logic [UMBRAL_W-1:0]  mf_q, vc_q, d_q;
  logic [NUM_FIFOS-1:0] chan_q, chan_d;
  logic [NUM_FIFOS-1:0] err;
  logic                 err_any;
  logic                 any_data;
  logic                 all_empty;

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_chk
    fifo_err_check u_chk (
      .fifo_empty_i (fifo_empty[g]),
      .fifo_full_i  (fifo_full[g]),
      .fifo_read_i  (fifo_read[g]),
      .fifo_write_i (fifo_write[g]),
      .err_o        (err[g])
    );
  end

  assign err_any   = |err;
  assign any_data  = |(~fifo_empty);
  assign all_empty = &fifo_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        if (!init) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (err_any)       state_d = S_ERROR;
        else if (init)     state_d = S_INIT;
        else if (any_data) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (err_any)        state_d = S_ERROR;
        else if (init)      state_d = S_INIT;
        else if (all_empty) state_d = S_IDLE;
      end
      S_ERROR: begin
`ifdef ERROR_RECOVERY_EN
        if (init) state_d = S_INIT;
`endif
      end
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    chan_d = '0;
    if (state_d == S_ERROR) begin
      if (state_q == S_ERROR) chan_d = chan_q | err;
      else                    chan_d = err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mf_q <= '0;
      vc_q <= '0;
      d_q  <= '0;
    end else if (state_q == S_INIT) begin
      mf_q <= umbral_mf_in;
      vc_q <= umbral_vc_in;
      d_q  <= umbral_d_in;
    end
  end

  assign init_out      = (state_q == S_INIT);
  assign idle_out      = (state_q == S_IDLE);
  assign active_out    = (state_q == S_ACTIVE);
  assign error_out     = (state_q == S_ERROR);
  assign state_out     = state_q;
  assign umbral_mf_out = mf_q;
  assign umbral_vc_out = vc_q;
  assign umbral_d_out  = d_q;
  assign error_chan    = chan_q;

endmodule
